// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

  localparam int SER_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in handshake and serial-out stream of the bit serializer.
interface bit_serializer_if #(
  parameter int WIDTH = ser_pkg::SER_WIDTH
) ();

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             x_out;
  logic             x_valid;

  modport master (
    output data_in, data_valid,
    input  data_ready, x_out, x_valid
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, x_out, x_valid
  );

endinterface

// File: rtl/ser_skid_buf.sv
// One-word holding buffer used by bit_serializer when SER_SKID_EN is defined.
module ser_skid_buf #(
  parameter int WIDTH = ser_pkg::SER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // NOTE: only the full flag is reset; the data word is never observed while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
    end else if (push) begin
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q <= din;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready input handshake.
// Optional macro SER_SKID_EN adds a one-word holding buffer for back-to-back words.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             x_valid_q, x_valid_d;
  logic             ready;
  logic             accept;

`ifdef SER_SKID_EN
  logic             buf_push;
  logic             buf_pop;
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;

  ser_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (bus.data_in),
    .dout  (buf_data),
    .full  (buf_full)
  );
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
`ifdef SER_SKID_EN
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    ready     = !reset && !buf_full;
`else
    ready     = !reset && ((state_q == IDLE) || (cnt_q == '0));
`endif
    accept    = bus.data_valid && ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shift_d = bus.data_in;
          cnt_d   = CNT_LAST;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          // Last bit: reload from buffer, then from the input, otherwise go idle.
`ifdef SER_SKID_EN
          if (buf_full) begin
            buf_pop = 1'b1;
            shift_d = buf_data;
            cnt_d   = CNT_LAST;
          end else if (accept) begin
            shift_d = bus.data_in;
            cnt_d   = CNT_LAST;
          end else begin
            state_d = IDLE;
            shift_d = '0;
          end
`else
          if (accept) begin
            shift_d = bus.data_in;
            cnt_d   = CNT_LAST;
          end else begin
            state_d = IDLE;
            shift_d = '0;
          end
`endif
        end else begin
`ifdef SER_SKID_EN
          buf_push = accept;
`endif
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase

    x_valid_d = (state_d == SHIFT);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      x_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      x_valid_q <= x_valid_d;
    end
  end

  assign bus.data_ready = ready;
  assign bus.x_out      = shift_q[WIDTH-1];
  assign bus.x_valid    = x_valid_q;

endmodule
